// File: rtl/mont_nprime_calc.sv
// Montgomery word constant nprime0 = -(n^-1) mod 2^WORD_W from the modulus low word.
// Bit-serial Hensel lifting: one inverse bit per clock, one WORD_W-bit adder.
module mont_nprime_calc #(
    parameter int unsigned N_WIDTH = 4096,
    parameter int unsigned WORD_W  = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic [N_WIDTH-1:0] n,
    output logic [WORD_W-1:0]  modulo_inv,
    output logic               valid,
    output logic               err,
    output logic               busy
);

    localparam int unsigned IDX_W = $clog2(WORD_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ITER  = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    logic [1:0]        state, state_d;
    logic [WORD_W-1:0] nw, nw_d;
    logic [WORD_W-1:0] y, y_d;
    logic [WORD_W-1:0] t, t_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [WORD_W-1:0] inv_d;
    logic              valid_d, err_d, busy_d;

    // Only the low word of the modulus takes part in the computation.
    logic unused_hi;
    assign unused_hi = ^n[N_WIDTH-1:WORD_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            nw         <= '0;
            y          <= '0;
            t          <= '0;
            idx        <= '0;
            modulo_inv <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            nw         <= nw_d;
            y          <= y_d;
            t          <= t_d;
            idx        <= idx_d;
            modulo_inv <= inv_d;
            valid      <= valid_d;
            err        <= err_d;
            busy       <= busy_d;
        end
    end

    // t tracks nw*y; a set bit t[idx] means bit idx of y must be set to clear it.
    always_comb begin
        state_d = state;
        nw_d    = nw;
        y_d     = y;
        t_d     = t;
        idx_d   = idx;
        inv_d   = modulo_inv;
        valid_d = valid;
        err_d   = err;
        busy_d  = busy;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    nw_d    = n[WORD_W-1:0];
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    if (!n[0]) begin
                        state_d = ST_ERR;
                    end else begin
                        y_d     = WORD_W'(1);
                        t_d     = n[WORD_W-1:0];
                        idx_d   = IDX_W'(1);
                        state_d = ST_ITER;
                    end
                end
            end
            ST_ITER: begin
                if (t[idx]) begin
                    y_d = y | (WORD_W'(1) << idx);
                    t_d = t + (nw << idx);
                end
                idx_d = idx + IDX_W'(1);
                if (idx == IDX_W'(WORD_W - 1)) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                inv_d   = ~y + WORD_W'(1);
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                inv_d   = '0;
                err_d   = 1'b1;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Low idx bits of nw*y are already 1; once all bits are lifted t is exactly 1.
    always @(posedge clk) begin
        if (reset && state == ST_ITER) begin
            assert (t == WORD_W'(nw * y));
            assert ((t & ((WORD_W'(1) << idx) - WORD_W'(1))) == WORD_W'(1));
        end
        if (reset && state == ST_FINAL) begin
            assert (t == WORD_W'(1));
        end
    end

endmodule

// File: tb/tb_mont_nprime_calc.sv
// Randomised self-checking bench for mont_nprime_calc against a Newton-iteration inverse model.
module tb_mont_nprime_calc;

    localparam int unsigned N_WIDTH = 4096;
    localparam int unsigned WORD_W  = 64;
    localparam int          LAT_MAX = 200;

    logic               clk;
    logic               reset;
    logic               go;
    logic [N_WIDTH-1:0] n;
    logic [WORD_W-1:0]  modulo_inv;
    logic               valid;
    logic               err;
    logic               busy;

    int checks;
    int failures;

    mont_nprime_calc #(.N_WIDTH(N_WIDTH), .WORD_W(WORD_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .n          (n),
        .modulo_inv (modulo_inv),
        .valid      (valid),
        .err        (err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N_WIDTH-1:0] rand_n();
        logic [N_WIDTH-1:0] r;
        for (int i = 0; i < int'(N_WIDTH / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Newton iteration x <- x*(2 - a*x) doubles correct bits; x=a is right to 3 bits for odd a.
    function automatic logic [WORD_W-1:0] ref_nprime(input logic [WORD_W-1:0] a);
        logic [WORD_W-1:0] x;
        x = a;
        for (int k = 0; k < 5; k++) x = x * (64'd2 - a * x);
        return 64'd0 - x;
    endfunction

    // Accept one go, then count cycles until valid; optionally pulse a stray go mid-run.
    task automatic run_op(input logic [N_WIDTH-1:0] nv, input int glitch_at, output int lat);
        @(negedge clk);
        n  = nv;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n  = rand_n();
        lat = 0;
        while (!valid && lat < LAT_MAX) begin
            if (lat == glitch_at) begin
                go = 1'b1;
                n  = rand_n() | N_WIDTH'(1);
            end else begin
                go = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        go = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        go    = 1'b0;
        n     = '0;
        repeat (3) @(negedge clk);
        checks++; if (modulo_inv !== 64'd0) begin failures++; $display("FAIL reset_inv got=%h exp=0", modulo_inv); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed(input logic [WORD_W-1:0] lo, input logic [WORD_W-1:0] exp_inv, input string name);
        logic [N_WIDTH-1:0] nv;
        logic [WORD_W-1:0]  prod;
        int lat;
        nv = rand_n();
        nv[WORD_W-1:0] = lo;
        run_op(nv, -1, lat);
        checks++; if (lat !== 64) begin failures++; $display("FAIL %s_latency got=%0d exp=64", name, lat); end
        checks++; if (valid !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL %s_flags got v=%b e=%b b=%b exp v=1 e=0 b=0", name, valid, err, busy);
        end
        checks++; if (modulo_inv !== exp_inv) begin failures++; $display("FAIL %s_inv got=%h exp=%h", name, modulo_inv, exp_inv); end
        prod = lo * modulo_inv;
        checks++; if (prod !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL %s_product got=%h exp=ffffffffffffffff", name, prod); end
    endtask

    task automatic test_three_inverse();
        logic [WORD_W-1:0] p;
        p = 64'd3 * (~modulo_inv + 64'd1);
        checks++; if (p !== 64'd1) begin failures++; $display("FAIL three_times_inverse got=%h exp=1", p); end
    endtask

    task automatic test_even_then_odd();
        logic [N_WIDTH-1:0] nv;
        int lat;
        nv = rand_n();
        nv[WORD_W-1:0] = 64'd4;
        run_op(nv, -1, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL even_latency got=%0d exp=1", lat); end
        checks++; if (valid !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL even_flags got v=%b e=%b exp v=1 e=1", valid, err); end
        checks++; if (modulo_inv !== 64'd0) begin failures++; $display("FAIL even_inv got=%h exp=0", modulo_inv); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL even_busy got=%b exp=0", busy); end
        repeat (3) @(negedge clk);
        checks++; if (valid !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL even_hold got v=%b e=%b exp v=1 e=1", valid, err); end
        nv = rand_n() | N_WIDTH'(1);
        @(negedge clk);
        n  = nv;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        checks++; if (valid !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL go_clears got v=%b e=%b b=%b exp v=0 e=0 b=1", valid, err, busy);
        end
        lat = 0;
        while (!valid && lat < LAT_MAX) begin @(negedge clk); lat++; end
        checks++; if (lat !== 64 || err !== 1'b0) begin failures++; $display("FAIL odd_after_even got lat=%0d e=%b exp lat=64 e=0", lat, err); end
        checks++; if (modulo_inv !== ref_nprime(nv[WORD_W-1:0])) begin
            failures++; $display("FAIL odd_after_even_inv got=%h exp=%h", modulo_inv, ref_nprime(nv[WORD_W-1:0]));
        end
    endtask

    task automatic test_random(input int count);
        logic [N_WIDTH-1:0] nv;
        logic [WORD_W-1:0]  lo, exp_inv, prod;
        int lat;
        for (int it = 0; it < count; it++) begin
            nv = rand_n() | N_WIDTH'(1);
            lo = nv[WORD_W-1:0];
            exp_inv = ref_nprime(lo);
            run_op(nv, (it % 10 == 0) ? 10 : -1, lat);
            prod = lo * modulo_inv + 64'd1;
            checks++; if (lat !== 64 || err !== 1'b0) begin failures++; $display("FAIL rand%0d_latency got lat=%0d e=%b exp lat=64 e=0", it, lat, err); end
            checks++; if (modulo_inv !== exp_inv) begin failures++; $display("FAIL rand%0d_inv n=%h got=%h exp=%h", it, lo, modulo_inv, exp_inv); end
            checks++; if (prod !== 64'd0) begin failures++; $display("FAIL rand%0d_product got=%h exp=0", it, prod); end
        end
    endtask

    task automatic test_reset_mid();
        logic [N_WIDTH-1:0] nv;
        int lat;
        nv = rand_n() | N_WIDTH'(1);
        @(negedge clk);
        n  = nv;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (29) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (modulo_inv !== 64'd0 || valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid got inv=%h v=%b e=%b b=%b exp all 0", modulo_inv, valid, err, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_mid_idle got v=%b b=%b exp 0 0", valid, busy); end
        nv = rand_n() | N_WIDTH'(1);
        run_op(nv, -1, lat);
        checks++; if (lat !== 64) begin failures++; $display("FAIL after_reset_latency got=%0d exp=64", lat); end
        checks++; if (modulo_inv !== ref_nprime(nv[WORD_W-1:0])) begin
            failures++; $display("FAIL after_reset_inv got=%h exp=%h", modulo_inv, ref_nprime(nv[WORD_W-1:0]));
        end
    endtask

    task automatic test_go_held();
        logic [N_WIDTH-1:0] nv;
        int lat;
        nv = rand_n() | N_WIDTH'(1);
        @(negedge clk);
        n  = nv;
        go = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!valid && lat < LAT_MAX) begin @(negedge clk); lat++; end
        checks++; if (lat !== 64 || modulo_inv !== ref_nprime(nv[WORD_W-1:0])) begin
            failures++; $display("FAIL go_held_first got lat=%0d inv=%h exp lat=64 inv=%h", lat, modulo_inv, ref_nprime(nv[WORD_W-1:0]));
        end
        @(negedge clk);
        go = 1'b0;
        checks++; if (valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL go_held_restart got v=%b b=%b exp v=0 b=1", valid, busy); end
        lat = 0;
        while (!valid && lat < LAT_MAX) begin @(negedge clk); lat++; end
        checks++; if (lat !== 64 || modulo_inv !== ref_nprime(nv[WORD_W-1:0])) begin
            failures++; $display("FAIL go_held_second got lat=%0d inv=%h exp lat=64", lat, modulo_inv);
        end
        repeat (3) @(negedge clk);
        checks++; if (valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL go_held_settle got v=%b b=%b exp v=1 b=0", valid, busy); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, "one");
        test_directed(64'd3, 64'h5555_5555_5555_5555, "three");
        test_three_inverse();
        test_directed(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "all_ones");
        test_even_then_odd();
        test_go_held();
        test_reset_mid();
        test_random(1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
